// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared constants and state encoding for the GPR file
//
// Purpose : register-file bus widths, named constants and the 1-bit FSM
//           state encoding used by wb_regfile and wb_regfile_if.
// Ports   : none (package).
// Config  : REGFILE_BYPASS_EN (used in wb_regfile.sv) enables same-cycle
//           write-to-read forwarding.

package wb_regfile_pkg;

  localparam int REG_BUS_W  = 32;  // register width
  localparam int REG_ADDR_W = 5;   // register address width
  localparam int REG_NUM    = 32;  // architectural register count

  localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
  localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;
  localparam logic                  WRITE_ENABLE = 1'b1;
  localparam logic                  READ_ENABLE  = 1'b1;
  localparam logic                  RST_ENABLE   = 1'b1;

  // INIT sweeps zeros into storage, RUN serves the pipeline.
  typedef enum logic {
    REG_INIT_STATE = 1'b0,
    REG_RUN_STATE  = 1'b1
  } rf_state_e;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - write-back / operand-read bus of the GPR file
//
// Purpose : bundles the write-back port, the two ID-stage read ports and the
//           init stall request.
// Signals : we/waddr/wdata   write-back from MEM/WB
//           re1/raddr1/rdata1 read port 1
//           re2/raddr2/rdata2 read port 2
//           init_busy         stall request while the file zeroes itself
// Modports: master (pipeline side), slave (register file side).

interface wb_regfile_if
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = REG_BUS_W,
  parameter int ADDR_W = REG_ADDR_W
);

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re1;
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              re2;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              init_busy;

  modport master (
    output we, waddr, wdata, re1, raddr1, re2, raddr2,
    input  rdata1, rdata2, init_busy
  );

  modport slave (
    input  we, waddr, wdata, re1, raddr1, re2, raddr2,
    output rdata1, rdata2, init_busy
  );

endinterface

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - architectural GPR file with self-zeroing init sequencer
//
// Purpose : 2-read / 1-write register file fed by the MEM/WB write-back
//           bundle. Storage carries no reset; after every reset an init
//           sequencer writes zero to r1..r(NUM_REGS-1) and raises init_busy
//           as a pipeline stall request. r0 always reads as zero.
// Ports   : clk  - system clock, all state on rising edge
//           rst  - synchronous active-high reset
//           bus  - wb_regfile_if.slave (write port, two combinational read
//                  ports, init_busy)
// Config  : REGFILE_BYPASS_EN - when defined, a read whose address matches the
//           write in the same cycle returns wdata; otherwise reads return the
//           pre-write storage contents.

module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = REG_BUS_W,
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int NUM_REGS = REG_NUM     // must equal 2**ADDR_W
) (
  input  logic          clk,
  input  logic          rst,
  wb_regfile_if.slave   bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR  = '0;

  rf_state_e         state;
  rf_state_e         state_next;
  logic [ADDR_W-1:0] init_ptr;
  logic [ADDR_W-1:0] init_ptr_next;
  logic              init_wr;
  logic              run_wr;
  logic              in_init;

  logic [DATA_W-1:0] mem [NUM_REGS];

  // State register. The sweep starts at r1 because r0 is never stored.
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state    <= REG_INIT_STATE;
      init_ptr <= FIRST_ADDR;
    end else begin
      state    <= state_next;
      init_ptr <= init_ptr_next;
    end
  end

  // Next state. The pointer holds at the last address instead of wrapping.
  always_comb begin
    state_next    = state;
    init_ptr_next = init_ptr;
    if (state == REG_INIT_STATE) begin
      if (init_ptr == LAST_ADDR) begin
        state_next = REG_RUN_STATE;
      end else begin
        init_ptr_next = init_ptr + FIRST_ADDR;
      end
    end
  end

  // Outputs decoded from state; rst gates everything so reset itself stalls.
  always_comb begin
    in_init       = (rst == RST_ENABLE) || (state == REG_INIT_STATE);
    bus.init_busy = in_init;
    init_wr       = (rst != RST_ENABLE) && (state == REG_INIT_STATE);
    run_wr        = !in_init && (bus.we == WRITE_ENABLE) && (bus.waddr != ZERO_ADDR);
  end

  // Single write port shared by the sweep and the write-back path.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      mem[init_ptr] <= '0;
    end else if (run_wr) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Read port 1
  always_comb begin
    bus.rdata1 = '0;
    if (in_init || (bus.re1 != READ_ENABLE) || (bus.raddr1 == ZERO_ADDR)) begin
      bus.rdata1 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if ((bus.we == WRITE_ENABLE) && (bus.waddr == bus.raddr1)) begin
      bus.rdata1 = bus.wdata;
`endif
    end else begin
      bus.rdata1 = mem[bus.raddr1];
    end
  end

  // Read port 2
  always_comb begin
    bus.rdata2 = '0;
    if (in_init || (bus.re2 != READ_ENABLE) || (bus.raddr2 == ZERO_ADDR)) begin
      bus.rdata2 = '0;
`ifdef REGFILE_BYPASS_EN
    end else if ((bus.we == WRITE_ENABLE) && (bus.waddr == bus.raddr2)) begin
      bus.rdata2 = bus.wdata;
`endif
    end else begin
      bus.rdata2 = mem[bus.raddr2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile
//
// Purpose : table vectors, hand-written reset/init sequences and randomized
//           traffic compared against an array-based register model.
// Ports   : none (top-level bench). Honours REGFILE_BYPASS_EN.

module tb_wb_regfile;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] model [32];

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re1;
    logic [4:0]  ra1;
    logic        re2;
    logic [4:0]  ra2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic re1, input logic [4:0] ra1,
                       input logic re2, input logic [4:0] ra2);
    bus.we = we; bus.waddr = wa; bus.wdata = wd;
    bus.re1 = re1; bus.raddr1 = ra1;
    bus.re2 = re2; bus.raddr2 = ra2;
  endtask

  // Register-file semantics: r0 reads zero, optional forwarding, else array.
  function automatic logic [31:0] model_read(input logic re, input logic [4:0] ra,
                                             input logic we, input logic [4:0] wa,
                                             input logic [31:0] wd);
    if (!re || ra == 5'd0) return 32'h0;
    if (BYP && we && wa == ra) return wd;
    return model[ra];
  endfunction

  task automatic model_write(input logic we, input logic [4:0] wa, input logic [31:0] wd);
    if (we && wa != 5'd0) model[wa] = wd;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
  endtask

  // Number of cycles init_busy stays high from now, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (bus.init_busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic check_all_zero(input string name);
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(i));
      #1;
      check(name, bus.rdata1, 32'h0);
      check(name, bus.rdata2, 32'h0);
    end
  endtask

  initial begin
    int n;
    logic        rwe;
    logic [4:0]  rwa, rra1, rra2;
    logic [31:0] rwd;
    logic        rre1, rre2;
    logic [31:0] e1, e2;

    vt[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  1'b1, 5'd0,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
    vt[1] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd5,  32'hDEADBEEF, 32'h0};
    vt[2] = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b1, 5'd5,  32'h0, 32'hDEADBEEF};
    vt[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  1'b1, 5'd0,  32'h0, 32'h0};
    vt[4] = '{1'b1, 5'd7,  32'h12345678, 1'b1, 5'd7,  1'b1, 5'd7,  BYP ? 32'h12345678 : 32'h0, BYP ? 32'h12345678 : 32'h0};
    vt[5] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  1'b1, 5'd7,  32'h12345678, 32'h12345678};
    vt[6] = '{1'b1, 5'd31, 32'hCAFEF00D, 1'b1, 5'd31, 1'b0, 5'd31, BYP ? 32'hCAFEF00D : 32'h0, 32'h0};
    vt[7] = '{1'b1, 5'd31, 32'h11111111, 1'b1, 5'd31, 1'b1, 5'd7,  BYP ? 32'h11111111 : 32'hCAFEF00D, 32'h12345678};
    vt[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 1'b1, 5'd31, 32'h11111111, 32'h11111111};

    model_clear();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd9);

    // Reset held two cycles.
    tick();
    tick();
    check("rst_busy", 32'(bus.init_busy), 32'h1);
    check("rst_rdata1", bus.rdata1, 32'h0);
    check("rst_rdata2", bus.rdata2, 32'h0);

    // Init timing.
    rst = 1'b0;
    #1;
    check("init_rdata1", bus.rdata1, 32'h0);
    count_busy(n);
    check("init_len", 32'(n), 32'd31);
    check("run_busy", 32'(bus.init_busy), 32'h0);
    check_all_zero("init_zero");

    // Table vectors.
    for (int i = 0; i < 9; i++) begin
      drive(vt[i].we, vt[i].wa, vt[i].wd, vt[i].re1, vt[i].ra1, vt[i].re2, vt[i].ra2);
      #1;
      check($sformatf("vec%0d_rdata1", i), bus.rdata1, vt[i].e1);
      check($sformatf("vec%0d_rdata2", i), bus.rdata2, vt[i].e2);
      tick();
      model_write(vt[i].we, vt[i].wa, vt[i].wd);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      rwe  = 1'($urandom_range(0, 1));
      rwa  = 5'($urandom_range(0, 31));
      rwd  = $urandom;
      rre1 = ($urandom_range(0, 7) != 0);
      rre2 = ($urandom_range(0, 7) != 0);
      rra1 = ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom_range(0, 31));
      rra2 = ($urandom_range(0, 3) == 0) ? rwa : 5'($urandom_range(0, 31));
      drive(rwe, rwa, rwd, rre1, rra1, rre2, rra2);
      e1 = model_read(rre1, rra1, rwe, rwa, rwd);
      e2 = model_read(rre2, rra2, rwe, rwa, rwd);
      #1;
      check("rand_rdata1", bus.rdata1, e1);
      check("rand_rdata2", bus.rdata2, e2);
      check("rand_busy", 32'(bus.init_busy), 32'h0);
      tick();
      model_write(rwe, rwa, rwd);
    end

    // Mid-run reset: r3 written, reset pulse, r4 write during INIT dropped.
    drive(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
    #1;
    check("midrun_r3", bus.rdata1, 32'hA5A5A5A5);
    rst = 1'b1;
    tick();
    check("midrun_rst_busy", 32'(bus.init_busy), 32'h1);
    rst = 1'b0;
    drive(1'b1, 5'd4, 32'h5A5A5A5A, 1'b1, 5'd4, 1'b0, 5'd0);
    #1;
    check("midrun_init_read", bus.rdata1, 32'h0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    count_busy(n);
    check("midrun_init_len", 32'(n + 1), 32'd31);
    model_clear();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b1, 5'd4);
    #1;
    check("midrun_r3_zero", bus.rdata1, 32'h0);
    check("midrun_r4_zero", bus.rdata2, 32'h0);

    // Reset asserted on init cycle 10 restarts the sweep.
    drive(1'b1, 5'd9, 32'hABCD0123, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b0, 5'd0);
    #1;
    check("reinit_r9_set", bus.rdata1, 32'hABCD0123);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("reinit_busy_early", 32'(bus.init_busy), 32'h1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    count_busy(n);
    check("reinit_len", 32'(n), 32'd31);
    check_all_zero("reinit_zero");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
